// File: rtl/receive_word_if.sv
// Pin bundle for receive_word: asynchronous serial inputs, consumer acknowledge, held word and status pulses.
// parityError is only present when RX_PARITY_EN is defined.
interface receive_word_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serialClock;
  logic             serialData;
  logic             wordAck;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             frameError;
  logic             overrun;
`ifdef RX_PARITY_EN
  logic             parityError;
`endif

  modport master (
    output serialClock, serialData, wordAck,
    input  ready, data, frameError, overrun
`ifdef RX_PARITY_EN
    , parityError
`endif
  );

  modport slave (
    input  serialClock, serialData, wordAck,
    output ready, data, frameError, overrun
`ifdef RX_PARITY_EN
    , parityError
`endif
  );
endinterface

// File: rtl/receive_word.sv
// Framed serial word receiver: synchronizes strobe/data, shifts MSB-first words into a one-deep holding register.
// Optional even-parity bit per word when RX_PARITY_EN is defined.
module receive_word #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           reset,
  receive_word_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sclk_q, sdat_q, warm_q;
  logic                   frame, bit_s, frame_prev;
  logic [CW-1:0]          count, count_d;
  logic [WIDTH-1:0]       shreg, shreg_d, next_word, word_c;
  logic                   word_done_c, frame_err_c;
  logic [WIDTH-1:0]       data_q;
  logic                   ready_q, ferr_q, ovr_q;
`ifdef RX_PARITY_EN
  logic                   parity_err_c, perr_q;
`endif

  assign frame     = sclk_q[SYNC_STAGES-1];
  assign bit_s     = sdat_q[SYNC_STAGES-1];
  assign next_word = {shreg[WIDTH-2:0], bit_s};

  // Synchronizers; frame_prev is held high until the chain has flushed out its reset zeros,
  // so a strobe already high at reset release never looks like a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q     <= '0;
      sdat_q     <= '0;
      warm_q     <= '0;
      frame_prev <= 1'b1;
    end else begin
      sclk_q     <= {sclk_q[SYNC_STAGES-2:0], bus.serialClock};
      sdat_q     <= {sdat_q[SYNC_STAGES-2:0], bus.serialData};
      warm_q     <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      frame_prev <= warm_q[SYNC_STAGES-1] ? frame : 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d     = state;
    count_d     = count;
    shreg_d     = shreg;
    word_done_c = 1'b0;
    word_c      = '0;
    frame_err_c = 1'b0;
`ifdef RX_PARITY_EN
    parity_err_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (frame && !frame_prev) begin
          shreg_d = WIDTH'(bit_s);
          count_d = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (frame) begin
          shreg_d = next_word;
          if (count == CW'(WIDTH - 1)) begin
`ifdef RX_PARITY_EN
            count_d = CW'(WIDTH);
            state_d = PARITY;
`else
            // Stay in SHIFT at count 0 so a following word needs no gap cycle.
            word_done_c = 1'b1;
            word_c      = next_word;
            count_d     = '0;
            shreg_d     = '0;
`endif
          end else begin
            count_d = count + CW'(1);
          end
        end else begin
          frame_err_c = (count != '0);
          count_d     = '0;
          shreg_d     = '0;
          state_d     = IDLE;
        end
      end
      PARITY: begin
`ifdef RX_PARITY_EN
        if (frame) begin
          if (^{shreg, bit_s}) begin
            parity_err_c = 1'b1;
          end else begin
            word_done_c = 1'b1;
            word_c      = shreg;
          end
          state_d = SHIFT;
        end else begin
          frame_err_c = 1'b1;
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
        count_d = '0;
        shreg_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        shreg_d = '0;
      end
    endcase
  end

  // Holding register: a completed word is dropped only if the held one is still unacknowledged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= frame_err_c;
      ovr_q  <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q <= parity_err_c;
`endif
      if (word_done_c) begin
        if (ready_q && !bus.wordAck) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= word_c;
          ready_q <= 1'b1;
        end
      end else if (bus.wordAck) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.data       = data_q;
  assign bus.frameError = ferr_q;
  assign bus.overrun    = ovr_q;
`ifdef RX_PARITY_EN
  assign bus.parityError = perr_q;
`endif
endmodule

// File: tb/tb_receive_word.sv
// Bench for receive_word (WIDTH=8, SYNC_STAGES=2): vector table plus hand-written multi-cycle sequences,
// with a queue of expected words compared whenever the DUT loads its holding register.
module tb_receive_word;
  localparam int S = 2;
`ifdef RX_PARITY_EN
  localparam int WL = 9;
`else
  localparam int WL = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  receive_word_if #(.WIDTH(8)) bus ();
  receive_word #(.WIDTH(8), .SYNC_STAGES(S)) dut (.clock(clk), .reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_n = 0;
  int ovr_n = 0;
  int perr_n = 0;
  int loads = 0;
  int load_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [7:0] word;
    int         nbits;
    logic       exp_ready;
    int         exp_ferr;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [7:0] w);
`ifdef RX_PARITY_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  always @(posedge clk) cyc++;

  // Pulse counters and load scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
      prev_data  = 8'h00;
    end else begin
      if (bus.frameError) ferr_n++;
      if (bus.overrun) ovr_n++;
`ifdef RX_PARITY_EN
      if (bus.parityError) perr_n++;
`endif
      if (bus.ready && (!prev_ready || bus.data != prev_data)) begin
        loads++;
        load_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got data %0h expected no load", bus.data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("load_data", 32'(bus.data), 32'(exp_w));
        end
      end
      prev_ready = bus.ready;
      prev_data  = bus.data;
    end
  end

  // Drives n bits MSB-first starting just after an edge, then frame low for tail cycles.
  task automatic send_frame(input logic [31:0] val, input int n, input int ack_cyc, input int tail);
    for (int c = 0; c < n + tail; c++) begin
      bus.serialClock = (c < n);
      bus.serialData  = (c < n) ? val[n-1-c] : 1'b0;
      bus.wordAck     = (c == ack_cyc);
      @(posedge clk);
      #1;
    end
    bus.wordAck = 1'b0;
  endtask

  task automatic ack_word();
    bus.wordAck = 1'b1;
    @(posedge clk);
    #1;
    bus.wordAck = 1'b0;
    chk("ready_after_ack", 32'(bus.ready), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, o0, l0, p0, start;
    logic [7:0] d0;
    logic [31:0] v;

    tbl[0] = '{word: 8'h00, nbits: 0, exp_ready: 1'b1, exp_ferr: 0};
    tbl[1] = '{word: 8'hFF, nbits: 0, exp_ready: 1'b1, exp_ferr: 0};
    tbl[2] = '{word: 8'h81, nbits: 0, exp_ready: 1'b1, exp_ferr: 0};
    tbl[3] = '{word: 8'hC0, nbits: 3, exp_ready: 1'b0, exp_ferr: 1};
    tbl[4] = '{word: 8'h80, nbits: 1, exp_ready: 1'b0, exp_ferr: 1};
    tbl[5] = '{word: 8'h5A, nbits: 7, exp_ready: 1'b0, exp_ferr: 1};
    tbl[6] = '{word: 8'h7E, nbits: 0, exp_ready: 1'b1, exp_ferr: 0};

    bus.serialClock = 1'b0;
    bus.serialData  = 1'b0;
    bus.wordAck     = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.ready), 0);
    chk("reset_data", 32'(bus.data), 0);
    chk("reset_frameError", 32'(bus.frameError), 0);
    chk("reset_overrun", 32'(bus.overrun), 0);

    // Short frame 1,1,0
    f0 = ferr_n;
    send_frame(32'b110, 3, -1, S + 4);
    chk("short_ferr", 32'(ferr_n - f0), 1);
    chk("short_ready", 32'(bus.ready), 0);
    chk("short_data", 32'(bus.data), 0);

    // 0xA5 with exact pin-to-ready latency
    f0 = ferr_n; o0 = ovr_n; start = cyc;
    exp_q.push_back(8'hA5);
    send_frame(32'(enc(8'hA5)), WL, -1, S + 3);
    chk("a5_latency", 32'(load_cyc - start), 32'(WL + S));
    chk("a5_ready", 32'(bus.ready), 1);
    chk("a5_data", 32'(bus.data), 32'hA5);
    chk("a5_ferr", 32'(ferr_n - f0), 0);
    chk("a5_ovr", 32'(ovr_n - o0), 0);
    ack_word();
    bus.wordAck = 1'b1;
    @(posedge clk);
    #1 bus.wordAck = 1'b0;
    chk("ack_when_idle_ready", 32'(bus.ready), 0);

    for (int i = 0; i < 7; i++) begin
      f0 = ferr_n; o0 = ovr_n; l0 = loads; d0 = bus.data;
      if (tbl[i].nbits == 0) begin
        exp_q.push_back(tbl[i].word);
        send_frame(32'(enc(tbl[i].word)), WL, -1, S + 3);
      end else begin
        v = 32'(tbl[i].word) >> (8 - tbl[i].nbits);
        send_frame(v, tbl[i].nbits, -1, S + 3);
      end
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_ferr", i), 32'(ferr_n - f0), 32'(tbl[i].exp_ferr));
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_n - o0), 0);
      chk($sformatf("vec%0d_data", i), 32'(bus.data), tbl[i].exp_ready ? 32'(tbl[i].word) : 32'(d0));
      chk($sformatf("vec%0d_loads", i), 32'(loads - l0), 32'(tbl[i].exp_ready));
      if (bus.ready) ack_word();
    end

    // Back-to-back words, acknowledged between them
    o0 = ovr_n; l0 = loads;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    v = (32'(enc(8'h3C)) << WL) | 32'(enc(8'hC3));
    send_frame(v, 2 * WL, WL + S + 2, S + 3);
    chk("b2b_ack_ovr", 32'(ovr_n - o0), 0);
    chk("b2b_ack_loads", 32'(loads - l0), 2);
    chk("b2b_ack_ready", 32'(bus.ready), 1);
    chk("b2b_ack_data", 32'(bus.data), 32'hC3);
    ack_word();

    // Back-to-back words, never acknowledged: second is an overrun
    o0 = ovr_n; l0 = loads;
    exp_q.push_back(8'h3C);
    send_frame(v, 2 * WL, -1, S + 3);
    chk("b2b_noack_ovr", 32'(ovr_n - o0), 1);
    chk("b2b_noack_loads", 32'(loads - l0), 1);
    chk("b2b_noack_ready", 32'(bus.ready), 1);
    chk("b2b_noack_data", 32'(bus.data), 32'h3C);
    ack_word();

    // Acknowledge in the very cycle the second word completes
    o0 = ovr_n; l0 = loads;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(v, 2 * WL, 2 * WL + S - 1, S + 3);
    chk("same_cyc_ovr", 32'(ovr_n - o0), 0);
    chk("same_cyc_loads", 32'(loads - l0), 2);
    chk("same_cyc_ready", 32'(bus.ready), 1);
    chk("same_cyc_data", 32'(bus.data), 32'hC3);

    // Reset mid-word with frame held high through release
    f0 = ferr_n; l0 = loads;
    bus.serialClock = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.serialData = c[0];
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(bus.ready), 0);
    chk("rst_mid_data", 32'(bus.data), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 2 * WL + S; c++) begin
      bus.serialData = c[1];
      @(posedge clk);
      #1;
    end
    send_frame(32'h0, 0, -1, S + 3);
    chk("rst_hold_loads", 32'(loads - l0), 0);
    chk("rst_hold_ferr", 32'(ferr_n - f0), 0);
    chk("rst_hold_ready", 32'(bus.ready), 0);
    chk("rst_hold_data", 32'(bus.data), 0);
    exp_q.push_back(8'h96);
    send_frame(32'(enc(8'h96)), WL, -1, S + 3);
    chk("post_rst_data", 32'(bus.data), 32'h96);
    chk("post_rst_ready", 32'(bus.ready), 1);
    ack_word();

`ifdef RX_PARITY_EN
    p0 = perr_n; l0 = loads;
    exp_q.push_back(8'hA5);
    send_frame({23'b0, 8'hA5, 1'b0}, 9, -1, S + 3);
    chk("par_good_data", 32'(bus.data), 32'hA5);
    chk("par_good_perr", 32'(perr_n - p0), 0);
    ack_word();
    send_frame({23'b0, 8'hA5, 1'b1}, 9, -1, S + 3);
    chk("par_bad_perr", 32'(perr_n - p0), 1);
    chk("par_bad_ready", 32'(bus.ready), 0);
    chk("par_bad_loads", 32'(loads - l0), 1);
`else
    p0 = perr_n;
    chk("no_parity_pulses", 32'(p0), 0);
`endif

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
